// File: rtl/node_pkg.sv
// Shared constants and helpers for the grid-node relaxation unit.
// Direction encoding: 0=N clockwise through 7=NW.
package node_pkg;

   localparam logic [2:0] DIR_N  = 3'd0;
   localparam logic [2:0] DIR_NE = 3'd1;
   localparam logic [2:0] DIR_E  = 3'd2;
   localparam logic [2:0] DIR_SE = 3'd3;
   localparam logic [2:0] DIR_S  = 3'd4;
   localparam logic [2:0] DIR_SW = 3'd5;
   localparam logic [2:0] DIR_W  = 3'd6;
   localparam logic [2:0] DIR_NW = 3'd7;

   localparam int PERP_DEF = 2;
   localparam int DIAG_DEF = 3;

   // 4-connected neighbours 0..3 are N,E,S,W, i.e. every other direction.
   function automatic logic [2:0] dir4_map(input logic [1:0] i);
      return {i, 1'b0};
   endfunction

   // Add and clip to the all-ones value of a cw-bit field.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input int cw);
      logic [32:0] s;
      logic [32:0] m;
      s = {1'b0, a} + {1'b0, b};
      m = (33'd1 << cw) - 33'd1;
      return (s > m) ? m[31:0] : s[31:0];
   endfunction

endpackage

// File: rtl/node_travel_cost.sv
// Combinational travel cost for the neighbour at idx: mux, weight, step, saturation.
// Latency: zero cycles; no flow control.
module node_travel_cost
   import node_pkg::*;
#(
   parameter int CW   = 16,
   parameter int WW   = 4,
   parameter int NB   = 8,
   parameter int PERP = PERP_DEF,
   parameter int DIAG = DIAG_DEF
) (
   input  logic [2:0]       idx,
   input  logic [WW-1:0]    weight,
   input  logic [NB*CW-1:0] nbr_cost,
   output logic [CW-1:0]    travel,
   output logic [2:0]       dir,
   output logic             adj_inf
);

   logic [CW-1:0] adj;
   logic [31:0]   extra;

   always_comb begin
      adj     = nbr_cost[int'(idx)*CW +: CW];
      adj_inf = &adj;
      dir     = (NB == 8) ? idx : dir4_map(idx[1:0]);
      extra   = (32'(weight) << 1) + (dir[0] ? 32'(DIAG) : 32'(PERP));
      travel  = CW'(sat_add(32'(adj), extra, CW));
   end

endmodule

// File: rtl/node_relax_unit.sv
// Per-cell shortest-path relaxation: scans one neighbour per enabled cycle, keeps min cost/dir.
// Latency: results registered, visible one cycle after evaluation; en=0 stalls, blocked weight freezes the scan.
module node_relax_unit
   import node_pkg::*;
#(
   parameter int CW   = 16,
   parameter int WW   = 4,
   parameter int NB   = 8,
   parameter int PERP = PERP_DEF,
   parameter int DIAG = DIAG_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             ld,
   input  logic [WW-1:0]    ld_weight,
   input  logic             en,
   input  logic [NB*CW-1:0] nbr_cost,
   output logic [CW-1:0]    path_cost,
   output logic [2:0]       path_dir,
   output logic             path_mod,
   output logic             sweep_done
);

   if ((NB != 4) && (NB != 8)) begin : g_nb_chk
      $error("node_relax_unit: NB must be 4 or 8");
   end
   if (CW + WW + 2 > 32) begin : g_width_chk
      $error("node_relax_unit: CW+WW+2 must fit in 32 bits");
   end

   logic [CW-1:0] cost_q, cost_d;
   logic [2:0]    dir_q, dir_d;
   logic [2:0]    idx_q, idx_d;
   logic [WW-1:0] weight_q, weight_d;
   logic          sw_chg_q, sw_chg_d;
   logic          path_mod_q, path_mod_d;
   logic          sweep_done_q, sweep_done_d;

   logic [CW-1:0] travel;
   logic [2:0]    cand_dir;
   logic          adj_inf;
   logic          scan, last, upd;

   node_travel_cost #(
      .CW(CW), .WW(WW), .NB(NB), .PERP(PERP), .DIAG(DIAG)
   ) u_travel (
      .idx      (idx_q),
      .weight   (weight_q),
      .nbr_cost (nbr_cost),
      .travel   (travel),
      .dir      (cand_dir),
      .adj_inf  (adj_inf)
   );

   always_comb begin
      scan = en && (weight_q != {WW{1'b1}});
      last = (idx_q == 3'(NB - 1));
      upd  = scan && !adj_inf && (travel < cost_q);

      cost_d       = cost_q;
      dir_d        = dir_q;
      idx_d        = idx_q;
      weight_d     = weight_q;
      sw_chg_d     = sw_chg_q;
      path_mod_d   = path_mod_q;
      sweep_done_d = 1'b0;

      if (clr) begin
         cost_d   = '0;
         dir_d    = DIR_N;
         sw_chg_d = 1'b1;
      end else if (upd) begin
         cost_d   = travel;
         dir_d    = cand_dir;
         sw_chg_d = 1'b1;
      end

      // A change in the final evaluation cycle still belongs to this sweep.
      if (scan) begin
         idx_d = last ? 3'd0 : idx_q + 3'd1;
         if (last) begin
            path_mod_d   = sw_chg_q | upd | clr;
            sw_chg_d     = 1'b0;
            sweep_done_d = 1'b1;
         end
      end

      if (ld) weight_d = ld_weight;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cost_q       <= '1;
         dir_q        <= DIR_N;
         idx_q        <= 3'd0;
         weight_q     <= '0;
         sw_chg_q     <= 1'b0;
         path_mod_q   <= 1'b1;
         sweep_done_q <= 1'b0;
      end else begin
         cost_q       <= cost_d;
         dir_q        <= dir_d;
         idx_q        <= idx_d;
         weight_q     <= weight_d;
         sw_chg_q     <= sw_chg_d;
         path_mod_q   <= path_mod_d;
         sweep_done_q <= sweep_done_d;
      end
   end

   assign path_cost  = cost_q;
   assign path_dir   = dir_q;
   assign path_mod   = path_mod_q;
   assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_node_relax_unit.sv
// Bench for node_relax_unit: NB=8 instance tracked cycle-by-cycle by a reference model
// through a scoreboard queue, plus directed checks on NB=8 and NB=4 instances.
module tb_node_relax_unit;

   logic         clk = 1'b0;
   logic         rst, clr, ld, en;
   logic [3:0]   ld_weight;
   logic [127:0] nbr8;
   logic [63:0]  nbr4;
   logic [15:0]  path_cost8, path_cost4;
   logic [2:0]   path_dir8, path_dir4;
   logic         path_mod8, path_mod4, sweep_done8, sweep_done4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   node_relax_unit #(.CW(16), .WW(4), .NB(8)) dut8 (
      .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_weight(ld_weight), .en(en),
      .nbr_cost(nbr8), .path_cost(path_cost8), .path_dir(path_dir8),
      .path_mod(path_mod8), .sweep_done(sweep_done8));

   node_relax_unit #(.CW(16), .WW(4), .NB(4)) dut4 (
      .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_weight(ld_weight), .en(en),
      .nbr_cost(nbr4), .path_cost(path_cost4), .path_dir(path_dir4),
      .path_mod(path_mod4), .sweep_done(sweep_done4));

   typedef struct {
      logic [15:0] cost;
      logic [2:0]  dir;
      logic        mod;
      logic        done;
   } exp_t;
   exp_t sb_q[$];

   // Reference model of the NB=8 instance (PERP=2, DIAG=3).
   int m_cost, m_dir, m_idx, m_w;
   bit m_mod, m_done, m_chg;
   int cyc = 0;

   task automatic model_push();
      exp_t e;
      int   adj, tc;
      bit   act, better, chg;
      if (rst) begin
         m_cost = 65535; m_dir = 0; m_idx = 0; m_w = 0;
         m_mod = 1'b1; m_done = 1'b0; m_chg = 1'b0;
      end else begin
         adj = int'(nbr8[m_idx*16 +: 16]);
         tc  = adj + 2 * m_w + ((m_idx % 2 == 1) ? 3 : 2);
         if (tc > 65535) tc = 65535;
         act    = en && (m_w != 15);
         better = act && (adj != 65535) && (tc < m_cost);
         chg    = m_chg | better | clr;
         if (clr) begin
            m_cost = 0; m_dir = 0;
         end else if (better) begin
            m_cost = tc; m_dir = m_idx;
         end
         m_done = 1'b0;
         if (act && m_idx == 7) begin
            m_mod = chg; m_chg = 1'b0; m_done = 1'b1;
         end else begin
            m_chg = chg;
         end
         if (act) m_idx = (m_idx + 1) % 8;
         if (ld) m_w = int'(ld_weight);
      end
      e.cost = 16'(m_cost); e.dir = 3'(m_dir); e.mod = m_mod; e.done = m_done;
      sb_q.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      model_push();
      @(posedge clk);
      #1;
      cyc++;
      total++;
      if (sb_q.size() == 0) begin
         bad++;
         $display("FAIL sb_empty cycle=%0d", cyc);
      end else begin
         e = sb_q.pop_front();
         if ({path_cost8, path_dir8, path_mod8, sweep_done8} !== {e.cost, e.dir, e.mod, e.done}) begin
            bad++;
            $display("FAIL sb_cycle%0d got cost=%h dir=%0d mod=%b done=%b want cost=%h dir=%0d mod=%b done=%b",
                     cyc, path_cost8, path_dir8, path_mod8, sweep_done8, e.cost, e.dir, e.mod, e.done);
         end
      end
   endtask

   task automatic fill8(input logic [15:0] v);
      for (int i = 0; i < 8; i++) nbr8[i*16 +: 16] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; ld = 1'b0; en = 1'b0; ld_weight = 4'd0;
      fill8(16'hFFFF);
      nbr4 = {4{16'hFFFF}};
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (path_cost8 !== 16'hFFFF) begin bad++; $display("FAIL rst_cost8 got=%h want=ffff", path_cost8); end
      total++; if (path_dir8 !== 3'd0) begin bad++; $display("FAIL rst_dir8 got=%0d want=0", path_dir8); end
      total++; if (path_mod8 !== 1'b1) begin bad++; $display("FAIL rst_mod8 got=%b want=1", path_mod8); end
      total++; if (sweep_done8 !== 1'b0) begin bad++; $display("FAIL rst_done8 got=%b want=0", sweep_done8); end
      total++; if ({path_cost4, path_mod4, sweep_done4} !== {16'hFFFF, 1'b1, 1'b0}) begin
         bad++; $display("FAIL rst_dut4 got cost=%h mod=%b done=%b want ffff/1/0", path_cost4, path_mod4, sweep_done4);
      end
   endtask

   task automatic test_tie();
      do_reset();
      ld = 1'b1; ld_weight = 4'd3; cycle(); ld = 1'b0;
      nbr8[15:0] = 16'd10; en = 1'b1;
      cycle();
      total++; if ({path_cost8, path_dir8} !== {16'd18, 3'd0}) begin
         bad++; $display("FAIL tie_first got cost=%0d dir=%0d want 18/0", path_cost8, path_dir8);
      end
      nbr8[31:16] = 16'd9;
      cycle();
      total++; if ({path_cost8, path_dir8} !== {16'd18, 3'd0}) begin
         bad++; $display("FAIL tie_keep got cost=%0d dir=%0d want 18/0", path_cost8, path_dir8);
      end
      for (int k = 0; k < 6; k++) cycle();
      total++; if ({sweep_done8, path_mod8} !== 2'b11) begin
         bad++; $display("FAIL tie_end got done=%b mod=%b want 1/1", sweep_done8, path_mod8);
      end
      en = 1'b0;
   endtask

   task automatic test_nb4();
      do_reset();
      nbr4 = {16'd5, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cycle();
         total++; if (sweep_done4 !== ((k % 4) == 3)) begin
            bad++; $display("FAIL nb4_done k=%0d got=%b want=%b", k, sweep_done4, (k % 4) == 3);
         end
      end
      total++; if ({path_cost4, path_dir4, path_mod4} !== {16'd7, 3'd6, 1'b0}) begin
         bad++; $display("FAIL nb4_result got cost=%0d dir=%0d mod=%b want 7/6/0", path_cost4, path_dir4, path_mod4);
      end
      en = 1'b0;
   endtask

   task automatic test_saturate();
      do_reset();
      ld = 1'b1; ld_weight = 4'd7; cycle(); ld = 1'b0;
      nbr8[15:0] = 16'hFFF0; en = 1'b1;
      for (int k = 0; k < 8; k++) cycle();
      total++; if ({path_cost8, path_mod8, sweep_done8} !== {16'hFFFF, 1'b0, 1'b1}) begin
         bad++; $display("FAIL sat_result got cost=%h mod=%b done=%b want ffff/0/1", path_cost8, path_mod8, sweep_done8);
      end
      en = 1'b0;
   endtask

   task automatic test_converge();
      do_reset();
      fill8(16'd40);
      nbr8[15:0] = 16'd20; nbr8[31:16] = 16'd30; nbr8[47:32] = 16'd10;
      en = 1'b1;
      for (int k = 0; k < 16; k++) cycle();
      total++; if ({path_cost8, path_dir8, path_mod8} !== {16'd12, 3'd2, 1'b0}) begin
         bad++; $display("FAIL conv_stable got cost=%0d dir=%0d mod=%b want 12/2/0", path_cost8, path_dir8, path_mod8);
      end
      cycle();
      nbr8[47:32] = 16'd9;
      for (int k = 0; k < 7; k++) cycle();
      total++; if ({path_cost8, path_dir8, path_mod8, sweep_done8} !== {16'd11, 3'd2, 1'b1, 1'b1}) begin
         bad++; $display("FAIL conv_lower got cost=%0d dir=%0d mod=%b done=%b want 11/2/1/1",
                         path_cost8, path_dir8, path_mod8, sweep_done8);
      end
      en = 1'b0;
   endtask

   task automatic test_clr();
      do_reset();
      clr = 1'b1; cycle(); clr = 1'b0;
      total++; if ({path_cost8, path_dir8} !== {16'd0, 3'd0}) begin
         bad++; $display("FAIL clr_seed got cost=%0d dir=%0d want 0/0", path_cost8, path_dir8);
      end
      en = 1'b1;
      for (int k = 0; k < 8; k++) cycle();
      total++; if ({path_cost8, path_dir8, path_mod8, sweep_done8} !== {16'd0, 3'd0, 1'b1, 1'b1}) begin
         bad++; $display("FAIL clr_sweep got cost=%0d dir=%0d mod=%b done=%b want 0/0/1/1",
                         path_cost8, path_dir8, path_mod8, sweep_done8);
      end
      en = 1'b0;
   endtask

   task automatic test_blocked();
      do_reset();
      nbr8[15:0] = 16'd10; en = 1'b1;
      for (int k = 0; k < 3; k++) cycle();
      en = 1'b0; ld = 1'b1; ld_weight = 4'hF; cycle(); ld = 1'b0;
      en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         total++; if ({path_cost8, path_mod8, sweep_done8} !== {16'd12, 1'b1, 1'b0}) begin
            bad++; $display("FAIL blk_frozen k=%0d got cost=%0d mod=%b done=%b want 12/1/0",
                            k, path_cost8, path_mod8, sweep_done8);
         end
      end
      en = 1'b0; ld = 1'b1; ld_weight = 4'd0; cycle(); ld = 1'b0;
      en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         total++; if (sweep_done8 !== (k == 4)) begin
            bad++; $display("FAIL blk_resume k=%0d got done=%b want=%b", k, sweep_done8, k == 4);
         end
      end
      en = 1'b0; ld = 1'b1; ld_weight = 4'hF; cycle(); ld = 1'b0;
      rst = 1'b1; cycle(); rst = 1'b0;
      total++; if ({path_cost8, path_dir8, path_mod8, sweep_done8} !== {16'hFFFF, 3'd0, 1'b1, 1'b0}) begin
         bad++; $display("FAIL blk_rst got cost=%h dir=%0d mod=%b done=%b want ffff/0/1/0",
                         path_cost8, path_dir8, path_mod8, sweep_done8);
      end
      en = 1'b1;
      for (int k = 0; k < 8; k++) cycle();
      total++; if (sweep_done8 !== 1'b1) begin
         bad++; $display("FAIL blk_rst_unblocked got done=%b want=1", sweep_done8);
      end
      en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; ld = 1'b0; en = 1'b0; ld_weight = 4'd0;
      nbr8 = '1; nbr4 = '1;
      test_reset();
      test_tie();
      test_nb4();
      test_saturate();
      test_converge();
      test_clr();
      test_blocked();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
